frame_buf_arbiter: RTL

FRAME_BUF_ARBITER -- requirements
Module: frame_buf_arbiter

---
 rtl/frame_buf_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/frame_buf_arbiter.sv
// frame_buf_arbiter
//   Arbitrates one shared pixel memory between a camera write stream and a
//   display read port. Camera beats are filtered by the latched mode (pass,
//   freeze, x-decimate, xy-decimate) and queued in a small write FIFO. Reads
//   always win the memory slot; queued writes drain on cycles without a read.
//
// Ports
//   Clk, Reset              clock (rising edge), async active-high reset
//   wr_valid/wr_ready       camera handshake; wr_ready = FIFO not full
//   wr_sof, wr_x, wr_y,     camera beat: start-of-frame flag, coordinates
//   wr_data                 and pixel
//   mode                    00 pass, 01 freeze, 10 x-decimate, 11 xy-decimate
//   rd_req, rd_x, rd_y      display read request and coordinates
//   rd_data, rd_valid       read result, three cycles after rd_req
//   mem_addr, mem_wdata,    registered memory command outputs
//   mem_we, mem_re
//   mem_rdata               memory read data, one cycle after mem_re
//   fifo_level              write FIFO occupancy, 0..FIFO_DEPTH
//   drop_cnt                saturating count of beats refused while full
module frame_buf_arbiter #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DROP_W     = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic                          wr_sof,
    input  logic [X_W-1:0]                wr_x,
    input  logic [Y_W-1:0]                wr_y,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [1:0]                    mode,
    input  logic                          rd_req,
    input  logic [X_W-1:0]                rd_x,
    input  logic [Y_W-1:0]                rd_y,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic [X_W+Y_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_we,
    output logic                          mem_re,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]             drop_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned AW    = X_W + Y_W;
    localparam int unsigned EW    = AW + DATA_W;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_FREEZE = 2'b01,
        MODE_XDEC   = 2'b10,
        MODE_XYDEC  = 2'b11
    } mode_e;

    logic [EW-1:0]     r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    mode_e             r_mode_q;
    logic [DROP_W-1:0] r_drop;
    logic [AW-1:0]     r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_mem_re;
    logic              r_re_d1;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_enq;
    logic [AW-1:0]     w_waddr;
    mode_e             w_mode;
    logic [EW-1:0]     w_head;

    assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_accept = wr_valid & ~w_full;
    // A start-of-frame beat is governed by the mode it carries, not the old one.
    assign w_mode   = wr_sof ? mode_e'(mode) : r_mode_q;
    assign w_push   = w_accept & w_enq;
    assign w_pop    = ~rd_req & ~w_empty;
    assign w_head   = r_fifo[r_rd_ptr];

    always_comb begin
        w_enq   = 1'b0;
        w_waddr = '0;
        unique case (w_mode)
            MODE_PASS: begin
                w_enq   = 1'b1;
                w_waddr = {wr_y, wr_x};
            end
            MODE_FREEZE: begin
                w_enq   = 1'b0;
            end
            MODE_XDEC: begin
                w_enq   = ~wr_x[0];
                w_waddr = {wr_y, 1'b0, wr_x[X_W-1:1]};
            end
            MODE_XYDEC: begin
                w_enq   = ~wr_x[0] & ~wr_y[0];
                w_waddr = {1'b0, wr_y[Y_W-1:1], 1'b0, wr_x[X_W-1:1]};
            end
        endcase
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {w_waddr, wr_data};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_mode_q    <= MODE_PASS;
            r_drop      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_re_d1     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            if (w_accept && wr_sof) begin
                r_mode_q <= mode_e'(mode);
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase

            if (wr_valid && w_full && !(&r_drop)) begin
                r_drop <= r_drop + DROP_W'(1);
            end

            // One memory slot per cycle; a read request always takes it.
            r_mem_re <= rd_req;
            r_mem_we <= w_pop;
            if (rd_req) begin
                r_mem_addr <= {rd_y, rd_x};
            end else if (w_pop) begin
                r_mem_addr  <= w_head[EW-1:DATA_W];
                r_mem_wdata <= w_head[DATA_W-1:0];
            end

            // mem_re -> memory returns data next cycle -> captured here.
            r_re_d1    <= r_mem_re;
            r_rd_valid <= r_re_d1;
            if (r_re_d1) begin
                r_rd_data <= mem_rdata;
            end
        end
    end

    assign wr_ready   = ~w_full;
    assign fifo_level = r_level;
    assign drop_cnt   = r_drop;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;
    assign mem_re     = r_mem_re;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;

endmodule
